// File: rtl/hba_arbiter_rr.sv
// rtl/hba_arbiter_rr.sv - round-robin bus arbiter with transfer timeout and forced ack
module hba_arbiter_rr #(
    parameter  int NUM_MASTERS    = 4,
    parameter  int TIMEOUT_CYCLES = 255,
    parameter  int ERRCNT_WIDTH   = 8,
    localparam int IDW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    hba_clk,
    input  logic                    hba_reset,
    input  logic [NUM_MASTERS-1:0]  hba_mrequest,
    input  logic                    hba_select,
    input  logic                    hba_xferack,
    output logic [NUM_MASTERS-1:0]  hba_mgrant,
    output logic                    hba_xferack_to,
    output logic                    bus_error,
    output logic [ERRCNT_WIDTH-1:0] error_count,
    output logic [IDW-1:0]          grant_id
);

    localparam int             CNTW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0]  LAST_RST = IDW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t                  state, state_nx;
    logic [CNTW-1:0]         cnt, cnt_nx;
    logic [IDW-1:0]          last, last_nx;
    logic [IDW-1:0]          gid_nx;
    logic [NUM_MASTERS-1:0]  mgrant_nx;
    logic                    ack_to_nx;
    logic                    err_nx;
    logic [ERRCNT_WIDTH-1:0] ecount_nx;

    logic                    found;
    logic [IDW-1:0]          pick;
    logic [NUM_MASTERS-1:0]  probe;

    // Round-robin search: first requester at or after last+1, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        probe = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            probe = NUM_MASTERS'(1) << ((int'(last) + i) % NUM_MASTERS);
            if (!found && ((hba_mrequest & probe) != '0)) begin
                found = 1'b1;
                pick  = IDW'((int'(last) + i) % NUM_MASTERS);
            end
        end
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last;
        gid_nx    = grant_id;
        mgrant_nx = hba_mgrant;
        ack_to_nx = 1'b0;
        err_nx    = 1'b0;
        ecount_nx = error_count;
        case (state)
            S_IDLE: begin
                mgrant_nx = '0;
                if (found) begin
                    gid_nx    = pick;
                    mgrant_nx = NUM_MASTERS'(1) << pick;
                    state_nx  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (hba_select) begin
                    cnt_nx   = '0;
                    state_nx = S_BUSY;
                end else if ((hba_mrequest & hba_mgrant) == '0) begin
                    // grantee withdrew before starting a transfer
                    mgrant_nx = '0;
                    last_nx   = grant_id;
                    state_nx  = S_IDLE;
                end
            end
            S_BUSY: begin
                if (hba_xferack) begin
                    state_nx = S_RELEASE;
                end else if (cnt == CNT_LAST) begin
                    ack_to_nx = 1'b1;
                    err_nx    = 1'b1;
                    if (error_count != '1) begin
                        ecount_nx = error_count + 1'b1;
                    end
                    state_nx = S_RELEASE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!hba_select) begin
                    mgrant_nx = '0;
                    last_nx   = grant_id;
                    state_nx  = S_IDLE;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                mgrant_nx = '0;
            end
        endcase
    end

    // State and registered outputs; reset wins from any state
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            last           <= LAST_RST;
            grant_id       <= '0;
            hba_mgrant     <= '0;
            hba_xferack_to <= 1'b0;
            bus_error      <= 1'b0;
            error_count    <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            last           <= last_nx;
            grant_id       <= gid_nx;
            hba_mgrant     <= mgrant_nx;
            hba_xferack_to <= ack_to_nx;
            bus_error      <= err_nx;
            error_count    <= ecount_nx;
        end
    end

endmodule

// File: tb/tb_hba_arbiter_rr.sv
// tb/tb_hba_arbiter_rr.sv - scoreboard bench for hba_arbiter_rr
module tb_hba_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       sel;
    logic       ack;
    logic [3:0] mgrant;
    logic       ack_to;
    logic       berr;
    logic [1:0] ecount;
    logic [1:0] gid;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [3:0] req_edge = '0;
    logic [3:0] prev_gnt = '0;

    always #5 clk = ~clk;

    hba_arbiter_rr #(
        .NUM_MASTERS   (4),
        .TIMEOUT_CYCLES(8),
        .ERRCNT_WIDTH  (2)
    ) dut (
        .hba_clk       (clk),
        .hba_reset     (rst),
        .hba_mrequest  (req),
        .hba_select    (sel),
        .hba_xferack   (ack | ack_to),
        .hba_mgrant    (mgrant),
        .hba_xferack_to(ack_to),
        .bus_error     (berr),
        .error_count   (ecount),
        .grant_id      (gid)
    );

    // request vector as seen at each rising edge
    always @(posedge clk) req_edge <= req;

    // grant monitor: one-hot, granted master was requesting, order matches scoreboard
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            checks++;
            if (!$onehot0(mgrant)) begin
                errors++;
                $display("FAIL grant_onehot: mgrant=%b", mgrant);
            end
            if (mgrant != '0 && prev_gnt == '0) begin
                checks++;
                if ((mgrant & req_edge) == '0) begin
                    errors++;
                    $display("FAIL grant_req_low: mgrant=%b req=%b", mgrant, req_edge);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: mgrant=%b grant_id=%0d", mgrant, gid);
                end else begin
                    e = exp_q.pop_front();
                    if (mgrant !== (4'b0001 << e) || gid !== 2'(e)) begin
                        errors++;
                        $display("FAIL grant_order: mgrant=%b grant_id=%0d expected master %0d", mgrant, gid, e);
                    end
                end
            end
        end
        prev_gnt = mgrant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (mgrant == '0 && n < 20);
        checks++;
        if (mgrant == '0) begin
            errors++;
            $display("FAIL grant_wait: no grant after %0d cycles, required a grant", n);
        end
    endtask

    task automatic finish_xfer(input int busy);
        sel = 1'b1;
        repeat (busy) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        sel = 1'b0;
        tick();
        checks++;
        if (mgrant !== 4'b0000) begin
            errors++;
            $display("FAIL release: mgrant=%b required 0000", mgrant);
        end
    endtask

    task automatic run_timeout(input logic [1:0] exp_cnt);
        int n;
        req = 4'b0000;
        sel = 1'b1;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!berr && n < 20);
        checks++;
        if (n != 8 || !berr || ack_to !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: after %0d cycles bus_error=%b xferack_to=%b required 8,1,1", n, berr, ack_to);
        end
        tick();
        checks++;
        if (berr !== 1'b0 || ack_to !== 1'b0 || mgrant == '0) begin
            errors++;
            $display("FAIL timeout_single: bus_error=%b xferack_to=%b mgrant=%b required 0,0,held", berr, ack_to, mgrant);
        end
        checks++;
        if (ecount !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_count: error_count=%0d required %0d", ecount, exp_cnt);
        end
        sel = 1'b0;
        tick();
        checks++;
        if (mgrant !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_release: mgrant=%b required 0000", mgrant);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        sel = 1'b0;
        ack = 1'b0;
        repeat (3) tick();
        checks++;
        if (mgrant !== 4'b0 || ack_to !== 1'b0 || berr !== 1'b0 || ecount !== 2'd0 || gid !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: mgrant=%b ack_to=%b berr=%b ecount=%0d gid=%0d required all zero",
                     mgrant, ack_to, berr, ecount, gid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL rr_gap: grant %0d after %0d cycles required 1", k, n);
            end
            if (k == 4) req = 4'b0000;
            finish_xfer(1);
        end
    endtask

    task automatic test_single();
        int n;
        req = 4'b0001;
        exp_q.push_back(0);
        wait_grant(n);
        checks++;
        if (n != 1 || mgrant !== 4'b0001) begin
            errors++;
            $display("FAIL single_latency: mgrant=%b after %0d cycles required 0001 after 1", mgrant, n);
        end
        req = 4'b0000;
        finish_xfer(3);
        checks++;
        if (ecount !== 2'd0 || berr !== 1'b0) begin
            errors++;
            $display("FAIL single_errors: error_count=%0d bus_error=%b required 0,0", ecount, berr);
        end
    endtask

    task automatic test_timeout();
        int n;
        req = 4'b0010;
        exp_q.push_back(1);
        wait_grant(n);
        run_timeout(2'd1);
    endtask

    task automatic test_ack_race();
        int n;
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(n);
        req = 4'b0000;
        sel = 1'b1;
        tick();
        repeat (7) tick();
        ack = 1'b1;
        tick();
        checks++;
        if (berr !== 1'b0 || ack_to !== 1'b0) begin
            errors++;
            $display("FAIL race_pulse: bus_error=%b xferack_to=%b required 0,0", berr, ack_to);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (berr !== 1'b0 || ecount !== 2'd1 || mgrant !== 4'b0100) begin
            errors++;
            $display("FAIL race_state: bus_error=%b error_count=%0d mgrant=%b required 0,1,0100", berr, ecount, mgrant);
        end
        sel = 1'b0;
        tick();
        checks++;
        if (mgrant !== 4'b0000) begin
            errors++;
            $display("FAIL race_release: mgrant=%b required 0000", mgrant);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic [1:0] expc;
        expc = 2'd1;
        for (int k = 0; k < 5; k++) begin
            if (expc != 2'd3) expc = expc + 2'd1;
            req = 4'b0001;
            exp_q.push_back(0);
            wait_grant(n);
            run_timeout(expc);
        end
    endtask

    task automatic test_withdraw();
        int n;
        req = 4'b0011;
        exp_q.push_back(1);
        wait_grant(n);
        req = 4'b0001;
        tick();
        checks++;
        if (mgrant !== 4'b0000) begin
            errors++;
            $display("FAIL withdraw_drop: mgrant=%b required 0000", mgrant);
        end
        exp_q.push_back(0);
        wait_grant(n);
        checks++;
        if (n != 1 || mgrant !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_next: mgrant=%b after %0d cycles required 0001 after 1", mgrant, n);
        end
        req = 4'b0000;
        finish_xfer(1);
    endtask

    task automatic test_reset_mid_busy();
        int n;
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(n);
        sel = 1'b1;
        req = 4'b0101;
        tick();
        tick();
        checks++;
        if (mgrant !== 4'b0100) begin
            errors++;
            $display("FAIL busy_hold: mgrant=%b required 0100", mgrant);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (mgrant !== 4'b0000 || ecount !== 2'd0 || gid !== 2'd0 || berr !== 1'b0) begin
            errors++;
            $display("FAIL midbusy_reset: mgrant=%b ecount=%0d gid=%0d berr=%b required 0000,0,0,0", mgrant, ecount, gid, berr);
        end
        rst = 1'b0;
        sel = 1'b0;
        exp_q.push_back(0);
        wait_grant(n);
        checks++;
        if (mgrant !== 4'b0001) begin
            errors++;
            $display("FAIL midbusy_regrant: mgrant=%b required 0001", mgrant);
        end
        req = 4'b0000;
        finish_xfer(1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_ack_race();
        test_saturation();
        test_withdraw();
        test_reset_mid_busy();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
